// File: rtl/vram_pkg.sv
// Shared constants and types for the video RAM arbiter: slot width, CPU
// handshake states and owner tags for in-flight RAM accesses.
package vram_pkg;

    localparam int DEF_ADDR_W = 14;
    localparam int SLOT_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DATA,
        ACK,
        HOLD
    } cpu_state_t;

    typedef enum logic [1:0] {
        NONE,
        VID,
        CPU
    } owner_t;

    // One in-flight pipeline stage: who owns the access and whether it writes.
    typedef struct packed {
        owner_t owner;
        logic   we;
    } stage_t;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer for the video RAM arbiter. It is loaded by
// an accepted CPU write and emptied once its drain grant has been issued.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [7:0]        cap_data,
    input  logic              drain,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data
);

    logic              full_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        data_reg;

    // Capture and drain never coincide: capture needs an empty buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg <= 1'b0;
            addr_reg <= '0;
            data_reg <= '0;
        end else if (capture) begin
            full_reg <= 1'b1;
            addr_reg <= cap_addr;
            data_reg <= cap_data;
        end else if (drain) begin
            full_reg <= 1'b0;
        end
    end

    assign full = full_reg;
    assign addr = addr_reg;
    assign data = data_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Slot-based arbiter sharing a single-port video RAM between the raster fetch
// and CPU cycles. Define VRAM_ARB_WBUF_EN to add a one-entry posted write buffer.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int VID_SLOT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slot_sync,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [7:0]        vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    logic [SLOT_W-1:0] slot_reg;
    cpu_state_t        state_reg;
    stage_t            st1_reg;
    stage_t            st2_reg;

    logic [ADDR_W-1:0] ram_addr_reg;
    logic [7:0]        ram_wdata_reg;
    logic              ram_we_reg;
    logic [7:0]        vid_data_reg;
    logic              vid_valid_reg;
    logic [7:0]        cpu_rdata_reg;
    logic              cpu_ack_reg;

    logic slot_is_vid;
    logic cpu_idle;
    logic cpu_grant;
    logic drain_grant;
    logic wr_capture;

    assign slot_is_vid = (slot_reg == SLOT_W'(VID_SLOT));
    assign cpu_idle    = (state_reg == IDLE);

`ifdef VRAM_ARB_WBUF_EN
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;

    // Writes go to the buffer; any CPU access waits while it still holds data,
    // so a later read always observes the posted write.
    assign drain_grant = buf_full & ~slot_is_vid;
    assign wr_capture  = cpu_idle & cpu_req & cpu_we & ~buf_full;
    assign cpu_grant   = cpu_idle & cpu_req & ~cpu_we & ~buf_full & ~slot_is_vid;

    vram_wbuf #(
        .ADDR_W(ADDR_W)
    ) u_wbuf (
        .clk     (clk),
        .reset   (reset),
        .capture (wr_capture),
        .cap_addr(cpu_addr),
        .cap_data(cpu_wdata),
        .drain   (drain_grant),
        .full    (buf_full),
        .addr    (buf_addr),
        .data    (buf_data)
    );
`else
    assign drain_grant = 1'b0;
    assign wr_capture  = 1'b0;
    assign cpu_grant   = cpu_idle & cpu_req & ~slot_is_vid;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg <= '0;
        end else if (slot_sync) begin
            slot_reg <= '0;
        end else begin
            slot_reg <= slot_reg + 1'b1;
        end
    end

    // RAM port: registered address/data, write strobe only in the cycle after grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            ram_we_reg    <= 1'b0;
        end else begin
            ram_we_reg <= 1'b0;
            if (slot_is_vid) begin
                ram_addr_reg <= vid_addr;
            end else if (drain_grant) begin
`ifdef VRAM_ARB_WBUF_EN
                ram_addr_reg  <= buf_addr;
                ram_wdata_reg <= buf_data;
                ram_we_reg    <= 1'b1;
`endif
            end else if (cpu_grant) begin
                ram_addr_reg <= cpu_addr;
                if (cpu_we) begin
                    ram_wdata_reg <= cpu_wdata;
                    ram_we_reg    <= 1'b1;
                end
            end
        end
    end

    // Owner tags follow each grant so the returning byte lands in the right place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st1_reg       <= '{owner: NONE, we: 1'b0};
            st2_reg       <= '{owner: NONE, we: 1'b0};
            vid_data_reg  <= '0;
            vid_valid_reg <= 1'b0;
            cpu_rdata_reg <= '0;
            cpu_ack_reg   <= 1'b0;
        end else begin
            if (slot_is_vid) begin
                st1_reg <= '{owner: VID, we: 1'b0};
            end else if (cpu_grant) begin
                st1_reg <= '{owner: CPU, we: cpu_we};
            end else begin
                st1_reg <= '{owner: NONE, we: 1'b0};
            end
            st2_reg <= st1_reg;

            vid_valid_reg <= (st2_reg.owner == VID);
            cpu_ack_reg   <= (st2_reg.owner == CPU) | wr_capture;
            if (st2_reg.owner == VID) begin
                vid_data_reg <= ram_rdata;
            end
            if ((st2_reg.owner == CPU) && !st2_reg.we) begin
                cpu_rdata_reg <= ram_rdata;
            end
        end
    end

    // HOLD keeps one long request from starting a second access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cpu_grant) begin
                        state_reg <= ISSUE;
                    end else if (wr_capture) begin
                        state_reg <= ACK;
                    end
                end
                ISSUE:   state_reg <= DATA;
                DATA:    state_reg <= ACK;
                ACK:     state_reg <= HOLD;
                HOLD: begin
                    if (!cpu_req) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cpu_wait  = cpu_req & ~cpu_ack_reg & (state_reg != HOLD);
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign ram_we    = ram_we_reg;
    assign vid_data  = vid_data_reg;
    assign vid_valid = vid_valid_reg;
    assign cpu_rdata = cpu_rdata_reg;
    assign cpu_ack   = cpu_ack_reg;

endmodule
